// File: rtl/double_pulse_meas.sv
// -----------------------------------------------------------------------------
// double_pulse_meas
//
// Timestamps a double-pulse burst on an asynchronous GPIO input relative to a
// start trigger. A falling edge on startclock arms the block and restarts the
// timebase. The first four pulse edges after arming (rise1, fall1, rise2, fall2)
// are captured into shadow registers. All four are published together, with a
// one-cycle meas_valid strobe, once fall2 is seen. An incomplete capture is
// aborted TIMEOUT cycles after arming and raises the sticky timeout_err.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   startclock   asynchronous trigger; a falling edge arms or re-arms a capture
//   pulse_in     asynchronous pulse input being measured
//   t_rise1      timestamp of the first rising edge  (CNT_W bits)
//   t_fall1      timestamp of the first falling edge (CNT_W bits)
//   t_rise2      timestamp of the second rising edge (CNT_W bits)
//   t_fall2      timestamp of the second falling edge (CNT_W bits)
//   meas_valid   one-cycle strobe when all four timestamps update
//   busy         high while a capture is armed
//   timeout_err  sticky abort flag, cleared by the next arm
// -----------------------------------------------------------------------------
module double_pulse_meas #(
   parameter int CNT_W       = 32,
   parameter int TIMEOUT     = 50000000,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             startclock,
   input  logic             pulse_in,
   output logic [CNT_W-1:0] t_rise1,
   output logic [CNT_W-1:0] t_fall1,
   output logic [CNT_W-1:0] t_rise2,
   output logic [CNT_W-1:0] t_fall2,
   output logic             meas_valid,
   output logic             busy,
   output logic             timeout_err
);

   typedef enum logic [2:0] {
      IDLE,
      W_R1,
      W_F1,
      W_R2,
      W_F2
   } state_t;

   localparam logic [CNT_W-1:0] LP_CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] LP_TO_LAST  = CNT_W'(TIMEOUT - 1);

   // Synchronizers and edge-history flops
   logic [SYNC_STAGES-1:0] r_trig_sync;
   logic [SYNC_STAGES-1:0] r_pulse_sync;
   logic                   r_trig_hist;
   logic                   r_pulse_hist;

   logic w_trig_fall;
   logic w_pulse_rise;
   logic w_pulse_fall;

   // FSM
   state_t r_state;
   state_t w_state_nxt;

   logic w_arm;
   logic w_cap_r1;
   logic w_cap_f1;
   logic w_cap_r2;
   logic w_done;
   logic w_abort;
   logic w_at_limit;
   logic w_busy;

   // Datapath
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_sh_r1;
   logic [CNT_W-1:0] r_sh_f1;
   logic [CNT_W-1:0] r_sh_r2;
   logic [CNT_W-1:0] r_t_rise1;
   logic [CNT_W-1:0] r_t_fall1;
   logic [CNT_W-1:0] r_t_rise2;
   logic [CNT_W-1:0] r_t_fall2;
   logic             r_meas_valid;
   logic             r_timeout_err;

   // --------------------------------------------------------------------------
   // Input synchronization. Both inputs see the same pin-to-detect latency, so
   // the offset cancels out of every timestamp and is left uncompensated.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state is always assigned with <= so that every flop
      // samples the pre-edge values of its neighbours, like real hardware.
      if (rst) begin
         r_trig_sync  <= '0;
         r_pulse_sync <= '0;
         r_trig_hist  <= 1'b0;
         r_pulse_hist <= 1'b0;
      end else begin
         r_trig_sync  <= {r_trig_sync[SYNC_STAGES-2:0], startclock};
         r_pulse_sync <= {r_pulse_sync[SYNC_STAGES-2:0], pulse_in};
         r_trig_hist  <= r_trig_sync[SYNC_STAGES-1];
         r_pulse_hist <= r_pulse_sync[SYNC_STAGES-1];
      end
   end

   assign w_trig_fall  =  r_trig_hist  & ~r_trig_sync[SYNC_STAGES-1];
   assign w_pulse_rise = ~r_pulse_hist &  r_pulse_sync[SYNC_STAGES-1];
   assign w_pulse_fall =  r_pulse_hist & ~r_pulse_sync[SYNC_STAGES-1];

   assign w_busy     = (r_state != IDLE);
   assign w_at_limit = (r_cnt == LP_TO_LAST);

   // --------------------------------------------------------------------------
   // FSM state register
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // --------------------------------------------------------------------------
   // FSM next-state and control decode. A trigger fall overrides everything,
   // including a pulse edge in the same cycle. In a wait state the expected
   // edge beats the timeout, so fall2 on the last cycle still completes.
   // --------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      w_state_nxt = r_state;
      w_arm       = 1'b0;
      w_cap_r1    = 1'b0;
      w_cap_f1    = 1'b0;
      w_cap_r2    = 1'b0;
      w_done      = 1'b0;
      w_abort     = 1'b0;

      if (w_trig_fall) begin
         w_arm       = 1'b1;
         w_state_nxt = W_R1;
      end else begin
         unique case (r_state)
            IDLE: begin
               w_state_nxt = IDLE;
            end
            W_R1: begin
               if (w_pulse_rise) begin
                  w_cap_r1    = 1'b1;
                  w_state_nxt = W_F1;
               end else if (w_at_limit) begin
                  w_abort     = 1'b1;
                  w_state_nxt = IDLE;
               end
            end
            W_F1: begin
               if (w_pulse_fall) begin
                  w_cap_f1    = 1'b1;
                  w_state_nxt = W_R2;
               end else if (w_at_limit) begin
                  w_abort     = 1'b1;
                  w_state_nxt = IDLE;
               end
            end
            W_R2: begin
               if (w_pulse_rise) begin
                  w_cap_r2    = 1'b1;
                  w_state_nxt = W_F2;
               end else if (w_at_limit) begin
                  w_abort     = 1'b1;
                  w_state_nxt = IDLE;
               end
            end
            W_F2: begin
               if (w_pulse_fall) begin
                  w_done      = 1'b1;
                  w_state_nxt = IDLE;
               end else if (w_at_limit) begin
                  w_abort     = 1'b1;
                  w_state_nxt = IDLE;
               end
            end
            default: begin
               w_state_nxt = IDLE;
            end
         endcase
      end
   end

   // --------------------------------------------------------------------------
   // Timebase, shadow captures and published results
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt         <= '0;
         r_sh_r1       <= '0;
         r_sh_f1       <= '0;
         r_sh_r2       <= '0;
         r_t_rise1     <= '0;
         r_t_fall1     <= '0;
         r_t_rise2     <= '0;
         r_t_fall2     <= '0;
         r_meas_valid  <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         r_meas_valid <= w_done;

         // Counter restarts on arm, saturates instead of wrapping, holds in IDLE.
         if (w_arm) begin
            r_cnt <= '0;
         end else if (w_busy && (r_cnt != LP_CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
         end

         // A re-arm throws away a partial capture.
         if (w_arm) begin
            r_sh_r1 <= '0;
            r_sh_f1 <= '0;
            r_sh_r2 <= '0;
         end else begin
            if (w_cap_r1) r_sh_r1 <= r_cnt;
            if (w_cap_f1) r_sh_f1 <= r_cnt;
            if (w_cap_r2) r_sh_r2 <= r_cnt;
         end

         // Outputs move only together, so they always describe one burst.
         // fall2 goes straight from the counter; it has no shadow of its own.
         if (w_done) begin
            r_t_rise1 <= r_sh_r1;
            r_t_fall1 <= r_sh_f1;
            r_t_rise2 <= r_sh_r2;
            r_t_fall2 <= r_cnt;
         end

         if (w_arm) begin
            r_timeout_err <= 1'b0;
         end else if (w_abort) begin
            r_timeout_err <= 1'b1;
         end
      end
   end

   assign t_rise1     = r_t_rise1;
   assign t_fall1     = r_t_fall1;
   assign t_rise2     = r_t_rise2;
   assign t_fall2     = r_t_fall2;
   assign meas_valid  = r_meas_valid;
   assign busy        = w_busy;
   assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_double_pulse_meas.sv
// -----------------------------------------------------------------------------
// tb_double_pulse_meas
//
// Directed bench for double_pulse_meas, built with TIMEOUT=1000.
//
// Timing reference: startclock is dropped 1 ns after a clock edge, and that
// edge is numbered 0. A pin change made just after edge m is seen by the block
// during the cycle after edge m+2. The arm edge is 3, where the counter loads 0.
// So a pulse change made after edge m carries timestamp m-1, and the resulting
// state transition happens at edge m+3.
// -----------------------------------------------------------------------------
module tb_double_pulse_meas;

   localparam int CNT_W = 32;
   localparam int TO    = 1000;

   logic             clk = 1'b0;
   logic             rst;
   logic             startclock;
   logic             pulse_in;
   logic [CNT_W-1:0] t_rise1;
   logic [CNT_W-1:0] t_fall1;
   logic [CNT_W-1:0] t_rise2;
   logic [CNT_W-1:0] t_fall2;
   logic             meas_valid;
   logic             busy;
   logic             timeout_err;

   int total  = 0;
   int bad    = 0;
   int mv_cnt = 0;
   int pos    = 0;

   double_pulse_meas #(
      .CNT_W      (CNT_W),
      .TIMEOUT    (TO),
      .SYNC_STAGES(2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .startclock (startclock),
      .pulse_in   (pulse_in),
      .t_rise1    (t_rise1),
      .t_fall1    (t_fall1),
      .t_rise2    (t_rise2),
      .t_fall2    (t_fall2),
      .meas_valid (meas_valid),
      .busy       (busy),
      .timeout_err(timeout_err)
   );

   always #10 clk = ~clk;

   // Count strobe cycles on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (meas_valid === 1'b1) mv_cnt++;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance to 1 ns after edge k, counted from the last trigger drop.
   task automatic to_edge(input int k);
      repeat (k - pos) @(posedge clk);
      #1;
      pos = k;
   endtask

   // Raise the trigger long enough to settle, then drop it just after an edge.
   task automatic arm();
      startclock = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      startclock = 1'b0;
      pos = 0;
   endtask

   initial begin
      rst        = 1'b1;
      startclock = 1'b1;
      pulse_in   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // ---- reset state ----
      check("rst_t_rise1", t_rise1, 0);
      check("rst_t_fall2", t_fall2, 0);
      check("rst_valid",   meas_valid, 0);
      check("rst_busy",    busy, 0);
      check("rst_tmo",     timeout_err, 0);

      // ---- 1: basic burst 100/200/300/450 ----
      arm();
      to_edge(2);   check("t1_busy_pre", busy, 0);
      to_edge(3);   check("t1_busy_arm", busy, 1);
      to_edge(101); pulse_in = 1'b1;
      to_edge(201); pulse_in = 1'b0;
      to_edge(301); pulse_in = 1'b1;
      to_edge(451); pulse_in = 1'b0;
      to_edge(453); check("t1_busy_late", busy, 1);
                    check("t1_valid_early", meas_valid, 0);
      to_edge(454); check("t1_valid", meas_valid, 1);
                    check("t1_busy_done", busy, 0);
                    check("t1_r1", t_rise1, 100);
                    check("t1_f1", t_fall1, 200);
                    check("t1_r2", t_rise2, 300);
                    check("t1_f2", t_fall2, 450);
                    check("t1_tmo", timeout_err, 0);
      to_edge(455); check("t1_valid_drop", meas_valid, 0);
                    check("t1_mv_cnt", mv_cnt, 1);

      // ---- 2: pulse already high at arm ----
      pulse_in = 1'b1;
      arm();
      to_edge(51); pulse_in = 1'b0;
      to_edge(61); pulse_in = 1'b1;
      to_edge(71); pulse_in = 1'b0;
      to_edge(81); pulse_in = 1'b1;
      to_edge(91); pulse_in = 1'b0;
      to_edge(94); check("t2_valid", meas_valid, 1);
                   check("t2_r1", t_rise1, 60);
                   check("t2_f1", t_fall1, 70);
                   check("t2_r2", t_rise2, 80);
                   check("t2_f2", t_fall2, 90);
      to_edge(95); check("t2_mv_cnt", mv_cnt, 2);

      // ---- 3: timeout after a single pulse ----
      arm();
      to_edge(11);   pulse_in = 1'b1;
      to_edge(21);   pulse_in = 1'b0;
      to_edge(1002); check("t3_busy_last", busy, 1);
                     check("t3_tmo_pre", timeout_err, 0);
      to_edge(1003); check("t3_busy_abort", busy, 0);
                     check("t3_tmo", timeout_err, 1);
                     check("t3_valid", meas_valid, 0);
                     check("t3_keep_r1", t_rise1, 60);
                     check("t3_keep_f2", t_fall2, 90);
      to_edge(1010); check("t3_mv_cnt", mv_cnt, 2);
                     check("t3_tmo_sticky", timeout_err, 1);

      // ---- 4: re-arm mid-capture; arm also clears timeout_err ----
      arm();
      to_edge(3);  check("t4_tmo_clr", timeout_err, 0);
                   check("t4_busy", busy, 1);
      to_edge(11); pulse_in = 1'b1;
      to_edge(21); pulse_in = 1'b0;
      to_edge(25); startclock = 1'b1;
      to_edge(31); startclock = 1'b0;
      pos = 0;
      to_edge(3);  check("t4_rearm_busy", busy, 1);
                   check("t4_keep_r1", t_rise1, 60);
      to_edge(6);  pulse_in = 1'b1;
      to_edge(11); pulse_in = 1'b0;
      to_edge(21); pulse_in = 1'b1;
      to_edge(26); pulse_in = 1'b0;
      to_edge(29); check("t4_valid", meas_valid, 1);
                   check("t4_r1", t_rise1, 5);
                   check("t4_f1", t_fall1, 10);
                   check("t4_r2", t_rise2, 20);
                   check("t4_f2", t_fall2, 25);
      to_edge(30); check("t4_mv_cnt", mv_cnt, 3);

      // ---- 6: fall2 on the timeout cycle completes ----
      arm();
      to_edge(11);   pulse_in = 1'b1;
      to_edge(21);   pulse_in = 1'b0;
      to_edge(31);   pulse_in = 1'b1;
      to_edge(1000); pulse_in = 1'b0;
      to_edge(1003); check("t6_valid", meas_valid, 1);
                     check("t6_tmo", timeout_err, 0);
                     check("t6_busy", busy, 0);
                     check("t6_r2", t_rise2, 30);
                     check("t6_f2", t_fall2, TO - 1);
      to_edge(1004); check("t6_mv_cnt", mv_cnt, 4);

      // ---- 5: reset mid-capture ----
      arm();
      to_edge(11); pulse_in = 1'b1;
      to_edge(15); rst = 1'b1;
      to_edge(16); rst = 1'b0;
                   check("t5_r1", t_rise1, 0);
                   check("t5_f2", t_fall2, 0);
                   check("t5_busy", busy, 0);
                   check("t5_tmo", timeout_err, 0);
                   check("t5_valid", meas_valid, 0);
      to_edge(21); pulse_in = 1'b0;
      to_edge(31); pulse_in = 1'b1;
      to_edge(41); pulse_in = 1'b0;
      to_edge(60); check("t5_mv_cnt", mv_cnt, 4);
                   check("t5_busy_end", busy, 0);
                   check("t5_f1_end", t_fall1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
